// File: rtl/decoder_arbiter.sv
// decoder_arbiter: round-robin arbiter for four requesters, driving a 2-to-4 decoder select with a hold limit.
module decoder_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic       addr0,
  output logic       addr1,
  output logic       enable,
  output logic [3:0] grant,
  output logic       busy
);
  typedef enum logic {IDLE, GRANT} state_t;
  localparam logic [3:0] MH = 4'(MAX_HOLD);
  state_t     state;
  logic [1:0] ptr, addr, off, win;
  logic [3:0] hold_cnt, others, cand, rot;
  logic [7:0] dbl;
  logic       keep;
  // In GRANT the owner (== ptr) is excluded from the search, so it is only regranted when nobody else waits.
  always_comb begin
    others = req & ~(4'b0001 << ptr);
    cand   = state == GRANT ? others : req;
    dbl    = {cand, cand} >> (ptr + 2'd1);
    rot    = dbl[3:0];
    off    = rot[0] ? 2'd0 : rot[1] ? 2'd1 : rot[2] ? 2'd2 : 2'd3;
    win    = ptr + 2'd1 + off;
    keep   = req[ptr] && (hold_cnt < MH || others == 4'd0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd3;
      hold_cnt <= 4'd0;
      addr     <= 2'd0;
      enable   <= 1'b0;
    end else if (state == IDLE) begin
      if (|req) begin
        state    <= GRANT;
        enable   <= 1'b1;
        addr     <= win;
        ptr      <= win;
        hold_cnt <= 4'd1;
      end
    end else if (keep) begin
      hold_cnt <= hold_cnt == MH ? 4'd1 : hold_cnt + 4'd1;
    end else if (|others) begin
      addr     <= win;
      ptr      <= win;
      hold_cnt <= 4'd1;
    end else begin
      state    <= IDLE;
      enable   <= 1'b0;
      hold_cnt <= 4'd0;
    end
  end
  assign addr0 = addr[0];
  assign addr1 = addr[1];
  assign busy  = enable;
  assign grant = enable ? 4'b0001 << addr : 4'b0000;
endmodule
